// File: rtl/uart_tx.sv
// 8N1 UART transmitter (LSB first) fed by a byte FIFO; start bit leaves tx_o two cycles after a push into an idle, empty unit.
// Backpressure: ready_o = !full, with no dependence on valid_i; queued frames go out back-to-back with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_q, tx_nxt;
  logic          busy_q, busy_nxt;
  logic          baud_last;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign ready_o = ~full;
  // A full FIFO refuses the byte even when a pop frees a slot on the same edge.
  assign push    = valid_i & ~full;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign baud_last = (baud == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 1'b1;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_nxt = '0;
          // Chain straight into the next start bit so queued frames abut.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line lags the FSM by one register stage, so every bit keeps its full width.
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift[0];
      default: tx_nxt = 1'b1;
    endcase

    busy_nxt = (state != IDLE) || !empty;
  end

endmodule
